// File: rtl/uart_tx_engine_if.sv
// Connection bundle between the UART CSR block (master) and the transmit engine (slave).
// Carries the CSR-supplied frame settings, the tx_start clear pulse and the line status back.
interface uart_tx_engine_if;
  logic [31:0] i_clks_per_bit;
  logic [7:0]  i_tx_data;
  logic        i_tx_start;
  logic        i_irq_en;
  logic        o_tx_start_clear;
  logic        o_tx;
  logic        o_busy;
  logic        o_irq;

  modport master (
    output i_clks_per_bit, i_tx_data, i_tx_start, i_irq_en,
    input  o_tx_start_clear, o_tx, o_busy, o_irq
  );

  modport slave (
    input  i_clks_per_bit, i_tx_data, i_tx_start, i_irq_en,
    output o_tx_start_clear, o_tx, o_busy, o_irq
  );
endinterface

// File: rtl/uart_tx_engine.sv
// 8N1 UART transmitter, LSB first. Frame settings are latched when a frame starts and
// stay fixed until it ends; every output comes straight from a flop.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_IDLE  | line high, waiting for tx_start
//  ST_START | start bit (line low) for one bit period
//  ST_DATA  | eight data bits, LSB first, one bit period each
//  ST_STOP  | stop bit (line high); irq pulse on its final cycle
module uart_tx_engine #(
  parameter int DATA_BITS = 8,
  parameter int MIN_DIV   = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  uart_tx_engine_if.slave   bus
);

  localparam int BIT_W = $clog2(DATA_BITS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [31:0]      MIN_DIV_W = 32'(MIN_DIV);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

  logic [1:0]           state_q, state_d;
  logic [31:0]          cnt_q, cnt_d;
  logic [31:0]          div_q, div_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 clear_q, clear_d;
  logic                 irq_q, irq_d;

  logic                 bit_end;
  logic [31:0]          div_clamped;

  assign div_clamped = (bus.i_clks_per_bit < MIN_DIV_W) ? MIN_DIV_W : bus.i_clks_per_bit;
  // div_q is never below MIN_DIV outside IDLE, so div_q-1 cannot wrap when it matters.
  assign bit_end     = (cnt_q == (div_q - 32'd1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    clear_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_tx_start) begin
          state_d = ST_START;
          shift_d = bus.i_tx_data;
          div_d   = div_clamped;
          cnt_d   = 32'd0;
          bit_d   = '0;
          clear_d = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          cnt_d   = 32'd0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d   = 32'd0;
          shift_d = shift_q >> 1;
          if (bit_q == LAST_BIT) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          cnt_d   = 32'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 32'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered line lines up with the state.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
    irq_d = bus.i_irq_en && (state_d == ST_STOP) && (cnt_d == (div_d - 32'd1));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 32'd0;
      div_q   <= 32'd0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      clear_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      clear_q <= clear_d;
      irq_q   <= irq_d;
    end
  end

  assign bus.o_tx             = tx_q;
  assign bus.o_busy           = busy_q;
  assign bus.o_tx_start_clear = clear_q;
  assign bus.o_irq            = irq_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: stimulus queues expected frames, a negedge monitor
// compares the line, busy, clear and irq outputs cycle by cycle against a frame-level model.
module tb_uart_tx_engine;

  logic clk;
  logic rst;
  logic sw_set;
  logic csr_start;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0]  data;
    int unsigned div;
    bit          irq_en;
    bit          gap_check;
    int          abort_at;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   in_frame = 0;
  int   cyc = 0;
  int   idle_cnt = 0;

  uart_tx_engine_if bus ();

  uart_tx_engine #(.DATA_BITS(8), .MIN_DIV(2)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // CSR tx_start bit: set by a software write, hw-cleared on the edge after the clear pulse.
  always @(posedge clk) begin
    if (rst) csr_start <= 1'b0;
    else if (sw_set) csr_start <= 1'b1;
    else if (bus.o_tx_start_clear) csr_start <= 1'b0;
  end
  assign bus.i_tx_start = csr_start;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Line level for bit slot k of a frame: start, eight data bits LSB first, stop.
  function automatic logic ref_line(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return d[k-1];
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!in_frame && bus.o_busy === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: busy=1 with no frame queued (t=%0t)", $time);
        end else begin
          cur = sb.pop_front();
          in_frame = 1;
          cyc = 0;
          if (cur.gap_check) chk("idle_gap", idle_cnt, 1);
        end
      end
      if (in_frame) begin
        if (cur.abort_at == cyc) begin
          chk("abort_tx", {31'd0, bus.o_tx}, 1);
          chk("abort_busy", {31'd0, bus.o_busy}, 0);
          chk("abort_irq", {31'd0, bus.o_irq}, 0);
          in_frame = 0;
          idle_cnt = 1;
        end else if (cyc == 10 * cur.div) begin
          chk("end_busy", {31'd0, bus.o_busy}, 0);
          chk("end_tx", {31'd0, bus.o_tx}, 1);
          chk("end_irq", {31'd0, bus.o_irq}, 0);
          in_frame = 0;
          idle_cnt = 1;
        end else begin
          chk("line", {31'd0, bus.o_tx}, {31'd0, ref_line(cur.data, cyc / int'(cur.div))});
          chk("busy", {31'd0, bus.o_busy}, 1);
          chk("clear", {31'd0, bus.o_tx_start_clear}, {31'd0, (cyc == 0)});
          chk("irq", {31'd0, bus.o_irq},
              {31'd0, (cur.irq_en && cyc == 10 * int'(cur.div) - 1)});
          cyc++;
        end
      end else begin
        idle_cnt++;
        chk("idle_tx", {31'd0, bus.o_tx}, 1);
        chk("idle_irq", {31'd0, bus.o_irq}, 0);
        chk("idle_clear", {31'd0, bus.o_tx_start_clear}, 0);
      end
    end
  endtask

  task automatic start_frame(input logic [7:0] d, input logic [31:0] cpb, input bit ien,
                             input bit gap, input int abort_at);
    exp_t e;
    e.data      = d;
    e.div       = (cpb < 32'd2) ? 2 : cpb;
    e.irq_en    = ien;
    e.gap_check = gap;
    e.abort_at  = abort_at;
    sb.push_back(e);
    bus.i_tx_data      = d;
    bus.i_clks_per_bit = cpb;
    bus.i_irq_en       = ien;
    sw_set             = 1'b1;
    @(negedge clk);
    sw_set = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!(sb.size() == 0 && !in_frame) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL timeout: frames still pending after %0d cycles", budget);
      sb.delete();
      in_frame = 0;
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst                = 1'b1;
    sw_set             = 1'b0;
    bus.i_tx_data      = 8'h00;
    bus.i_clks_per_bit = 32'd4;
    bus.i_irq_en       = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_tx", {31'd0, bus.o_tx}, 1);
    chk("reset_busy", {31'd0, bus.o_busy}, 0);
    chk("reset_clear", {31'd0, bus.o_tx_start_clear}, 0);
    chk("reset_irq", {31'd0, bus.o_irq}, 0);
    rst = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);

    start_frame(8'hA5, 32'd4, 1'b1, 1'b0, -1);
    wait_done(200);

    start_frame(8'hFF, 32'd0, 1'b1, 1'b0, -1);
    wait_done(200);
    start_frame(8'hFF, 32'd1, 1'b1, 1'b0, -1);
    wait_done(200);

    // Queued second frame with settings changed while the first is on the line.
    start_frame(8'hA5, 32'd4, 1'b1, 1'b0, -1);
    repeat (10) @(negedge clk);
    start_frame(8'h3C, 32'd6, 1'b1, 1'b1, -1);
    wait_done(400);

    start_frame(8'h96, 32'd5, 1'b0, 1'b0, -1);
    wait_done(200);
    start_frame(8'h69, 32'd5, 1'b1, 1'b0, -1);
    wait_done(200);

    // Reset in the middle of data bit 3 (frame slot 4, cycles 16..19 at div 4).
    start_frame(8'hC3, 32'd4, 1'b1, 1'b0, 18);
    begin
      int n = 0;
      while (bus.o_busy !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_done(200);
    start_frame(8'h5A, 32'd3, 1'b1, 1'b0, -1);
    wait_done(200);

    start_frame(8'h00, 32'd2500, 1'b1, 1'b0, -1);
    wait_done(26000);

    for (int i = 0; i < 12; i++) begin
      logic [7:0]  d;
      logic [31:0] c;
      bit          ien;
      d   = 8'($urandom_range(0, 255));
      c   = 32'($urandom_range(0, 7));
      ien = 1'($urandom_range(0, 1));
      start_frame(d, c, ien, 1'b0, -1);
      if (i % 3 == 2) begin
        repeat (5) @(negedge clk);
        d = 8'($urandom_range(0, 255));
        c = 32'($urandom_range(0, 7));
        start_frame(d, c, ien, 1'b1, -1);
      end
      wait_done(400);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
